// File: rtl/inv_butterfly.sv
// Radix-2 DIF inverse butterfly: xa = (ya+yb)/2, xb = ((ya-yb)/2)*w, behind valid/ready.
// Define INV_BUTTERFLY_SAT_EN to saturate o_xb and report clamping on o_sat; otherwise o_xb wraps.
module inv_butterfly #(
   parameter int WIDTH = 8,
   parameter int FRAC  = WIDTH - 2
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_valid,
   output logic                    o_ready,
   input  logic signed [WIDTH-1:0] i_w,
   input  logic signed [WIDTH-1:0] i_ya,
   input  logic signed [WIDTH-1:0] i_yb,
   output logic                    o_valid,
   input  logic                    i_ready,
   output logic signed [WIDTH-1:0] o_xa,
   output logic signed [WIDTH-1:0] o_xb,
   output logic                    o_sat
);

   typedef enum logic [1:0] {S_IDLE, S_SUM, S_MUL, S_DONE} state_t;

   state_t state, state_next;

   logic signed [WIDTH-1:0]   ya_r, yb_r, w_r, s_r, d_r;
   logic signed [WIDTH:0]     sum, diff;
   logic signed [2*WIDTH-1:0] prod, q;
   logic signed [WIDTH-1:0]   xb_fit;

   // One guard bit keeps sum/difference exact; halving then always fits WIDTH bits.
   assign sum  = {ya_r[WIDTH-1], ya_r} + {yb_r[WIDTH-1], yb_r};
   assign diff = {ya_r[WIDTH-1], ya_r} - {yb_r[WIDTH-1], yb_r};
   assign prod = {{WIDTH{d_r[WIDTH-1]}}, d_r} * {{WIDTH{w_r[WIDTH-1]}}, w_r};
   assign q    = prod >>> FRAC;

`ifdef INV_BUTTERFLY_SAT_EN
   logic [WIDTH:0] q_hi;
   logic           q_fits;
   logic           sat_next;
   logic           sat_r;

   // q fits when every bit from the target sign bit upward is a copy of the sign.
   assign q_hi   = q[2*WIDTH-1:WIDTH-1];
   assign q_fits = (q_hi == '0) || (q_hi == '1);

   always_comb begin
      sat_next = !q_fits;
      xb_fit   = WIDTH'(q);
      if (!q_fits) begin
         if (q[2*WIDTH-1]) xb_fit = {1'b1, {(WIDTH-1){1'b0}}};
         else              xb_fit = {1'b0, {(WIDTH-1){1'b1}}};
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)              sat_r <= 1'b0;
      else if (state == S_MUL)   sat_r <= sat_next;
   end

   assign o_sat = sat_r;
`else
   assign xb_fit = WIDTH'(q);
   assign o_sat  = 1'b0;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state <= S_IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = S_IDLE;
      case (state)
         S_IDLE:  state_next = i_valid ? S_SUM : S_IDLE;
         S_SUM:   state_next = S_MUL;
         S_MUL:   state_next = S_DONE;
         S_DONE:  state_next = i_ready ? S_IDLE : S_DONE;
         default: state_next = S_IDLE;
      endcase
   end

   assign o_ready = (state == S_IDLE);
   assign o_valid = (state == S_DONE);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ya_r <= '0;
         yb_r <= '0;
         w_r  <= '0;
         s_r  <= '0;
         d_r  <= '0;
         o_xa <= '0;
         o_xb <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (i_valid) begin
                  ya_r <= i_ya;
                  yb_r <= i_yb;
                  w_r  <= i_w;
               end
            end
            S_SUM: begin
               s_r <= WIDTH'(sum >>> 1);
               d_r <= WIDTH'(diff >>> 1);
            end
            S_MUL: begin
               o_xa <= s_r;
               o_xb <= xb_fit;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_inv_butterfly.sv
// Randomized self-checking bench for inv_butterfly (WIDTH=8, FRAC=6) against an arithmetic model.
// Follows INV_BUTTERFLY_SAT_EN in the model so the same bench covers both builds.
module tb_inv_butterfly;

   logic              clk;
   logic              rst_n;
   logic              i_valid;
   logic              o_ready;
   logic signed [7:0] i_w, i_ya, i_yb;
   logic              o_valid;
   logic              i_ready;
   logic signed [7:0] o_xa, o_xb;
   logic              o_sat;

   int checks   = 0;
   int failures = 0;

   inv_butterfly #(.WIDTH(8), .FRAC(6)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .i_w     (i_w),
      .i_ya    (i_ya),
      .i_yb    (i_yb),
      .o_valid (o_valid),
      .i_ready (i_ready),
      .o_xa    (o_xa),
      .o_xb    (o_xb),
      .o_sat   (o_sat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
      end
   endtask

   function automatic int floorDiv(input int a, input int b);
      int r;
      r = a / b;
      if ((a % b != 0) && ((a < 0) != (b < 0))) r = r - 1;
      return r;
   endfunction

   // Reference: exact rational arithmetic with floor, then clamp or wrap into 8 bits.
   task automatic model(input int ya, input int yb, input int w,
                        output int xa, output int xb, output int sat);
      int d, q;
      xa  = floorDiv(ya + yb, 2);
      d   = floorDiv(ya - yb, 2);
      q   = floorDiv(d * w, 64);
      sat = 0;
`ifdef INV_BUTTERFLY_SAT_EN
      if (q > 127)       begin xb = 127;  sat = 1; end
      else if (q < -128) begin xb = -128; sat = 1; end
      else               xb = q;
`else
      xb = ((q % 256) + 256) % 256;
      if (xb >= 128) xb = xb - 256;
`endif
   endtask

   function automatic int rnd8();
      return int'($urandom_range(0, 255)) - 128;
   endfunction

   task automatic applyStimulus(input int ya, input int yb, input int w);
      i_ya = 8'(ya);
      i_yb = 8'(yb);
      i_w  = 8'(w);
   endtask

   // Full transaction: accept, measure latency, stall for `hold` cycles, then transfer.
   task automatic runOne(input string tag, input int ya, input int yb, input int w, input int hold);
      int exa, exb, esat, edges;
      bit got;
      logic signed [7:0] xa0, xb0;
      model(ya, yb, w, exa, exb, esat);
      @(negedge clk);
      edges = 0;
      while (!o_ready && edges < 10) begin
         @(negedge clk);
         edges++;
      end
      checkOutput({tag, "_ready_idle"}, int'(o_ready), 1);
      i_ready = 1'b0;
      i_valid = 1'b1;
      applyStimulus(ya, yb, w);
      edges = 0;
      got   = 1'b0;
      while (!got && edges < 10) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
         applyStimulus(rnd8(), rnd8(), rnd8());
         if (o_valid) got = 1'b1;
      end
      i_valid = 1'b0;
      checkOutput({tag, "_latency"}, edges, 3);
      checkOutput({tag, "_xa"}, int'(o_xa), exa);
      checkOutput({tag, "_xb"}, int'(o_xb), exb);
      checkOutput({tag, "_sat"}, int'(o_sat), esat);
      checkOutput({tag, "_ready_busy"}, int'(o_ready), 0);
      xa0 = o_xa;
      xb0 = o_xb;
      for (int i = 0; i < hold; i++) begin
         applyStimulus(rnd8(), rnd8(), rnd8());
         i_valid = 1'b1;
         @(negedge clk);
         i_valid = 1'b0;
         checkOutput({tag, "_stall_valid"}, int'(o_valid), 1);
         checkOutput({tag, "_stall_ready"}, int'(o_ready), 0);
         checkOutput({tag, "_stall_xa"}, int'(o_xa), int'(xa0));
         checkOutput({tag, "_stall_xb"}, int'(o_xb), int'(xb0));
      end
      i_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      i_ready = 1'b0;
      checkOutput({tag, "_post_valid"}, int'(o_valid), 0);
      checkOutput({tag, "_post_ready"}, int'(o_ready), 1);
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_valid"}, int'(o_valid), 0);
      checkOutput({tag, "_ready"}, int'(o_ready), 1);
      checkOutput({tag, "_xa"}, int'(o_xa), 0);
      checkOutput({tag, "_xb"}, int'(o_xb), 0);
      checkOutput({tag, "_sat"}, int'(o_sat), 0);
   endtask

   int bya[4], byb[4], bw[4], bxa[4], bxb[4], bsat[4];
   int acc_idx, out_idx, last_acc, cyc;

   initial begin
      rst_n   = 1'b0;
      i_valid = 1'b0;
      i_ready = 1'b0;
      applyStimulus(0, 0, 0);
      repeat (3) @(negedge clk);
      checkResetOutputs("reset_hold");
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checkResetOutputs("reset_idle");

      runOne("basic", 20, 10, 64, 5);
      runOne("floor_pos", 7, 0, 64, 0);
      runOne("floor_neg", -7, 0, 64, 0);
      runOne("floor_frac", 3, 0, 32, 1);
      runOne("ovf_pos", 127, -128, 127, 0);
      runOne("ovf_neg", 127, -128, -128, 0);

      for (int k = 0; k < 16; k++)
         runOne("rand", rnd8(), rnd8(), rnd8(), int'($urandom_range(0, 2)));

      // Back-to-back with both handshakes held high; garbage while busy must be ignored.
      for (int k = 0; k < 4; k++) begin
         bya[k] = rnd8();
         byb[k] = rnd8();
         bw[k]  = rnd8();
         model(bya[k], byb[k], bw[k], bxa[k], bxb[k], bsat[k]);
      end
      @(negedge clk);
      i_ready  = 1'b1;
      i_valid  = 1'b1;
      acc_idx  = 0;
      out_idx  = 0;
      last_acc = -1;
      cyc      = 0;
      while (out_idx < 4 && cyc < 40) begin
         if (o_valid) begin
            checkOutput("b2b_xa", int'(o_xa), bxa[out_idx]);
            checkOutput("b2b_xb", int'(o_xb), bxb[out_idx]);
            checkOutput("b2b_sat", int'(o_sat), bsat[out_idx]);
            out_idx++;
         end
         if (o_ready && acc_idx < 4) begin
            if (last_acc >= 0) checkOutput("b2b_accept_gap", cyc - last_acc, 4);
            last_acc = cyc;
            applyStimulus(bya[acc_idx], byb[acc_idx], bw[acc_idx]);
            acc_idx++;
         end else begin
            applyStimulus(rnd8(), rnd8(), rnd8());
            if (o_ready) i_valid = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      checkOutput("b2b_count", out_idx, 4);
      i_valid = 1'b0;
      i_ready = 1'b0;

      // Make held outputs nonzero so the reset clearing is visible.
      runOne("pre_rst", 127, -128, -128, 0);
      @(negedge clk);
      i_valid = 1'b1;
      applyStimulus(50, -20, 40);
      @(posedge clk);
      #1 i_valid = 1'b0;
      #1 rst_n = 1'b0;
      #1 checkResetOutputs("rst_sum");
      @(negedge clk);
      rst_n = 1'b1;
      runOne("after_rst_sum", -100, 60, 90, 0);

      @(negedge clk);
      i_valid = 1'b1;
      applyStimulus(-90, 37, -70);
      repeat (3) @(posedge clk);
      @(negedge clk);
      i_valid = 1'b0;
      checkOutput("rst_done_pre_valid", int'(o_valid), 1);
      #2 rst_n = 1'b0;
      #1 checkResetOutputs("rst_done");
      @(negedge clk);
      rst_n = 1'b1;
      runOne("after_rst_done", 33, -77, 100, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
